// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: load/store opcodes, FSM encoding,
// exception bit positions, request sizes and the request bundle.
package mem_stage_pkg;

  localparam logic [3:0] LS_NONE = 4'd0;
  localparam logic [3:0] LS_LB   = 4'd1;
  localparam logic [3:0] LS_LBU  = 4'd2;
  localparam logic [3:0] LS_LH   = 4'd3;
  localparam logic [3:0] LS_LHU  = 4'd4;
  localparam logic [3:0] LS_LW   = 4'd5;
  localparam logic [3:0] LS_SB   = 4'd6;
  localparam logic [3:0] LS_SH   = 4'd7;
  localparam logic [3:0] LS_SW   = 4'd8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int EXC_ADEL = 4;
  localparam int EXC_ADES = 5;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic ls_is_load(input logic [3:0] op);
    return (op == LS_LB) || (op == LS_LBU) || (op == LS_LH) ||
           (op == LS_LHU) || (op == LS_LW);
  endfunction

  function automatic logic ls_is_store(input logic [3:0] op);
    return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
  endfunction

  function automatic logic [1:0] ls_size(input logic [3:0] op);
    case (op)
      LS_LH, LS_LHU, LS_SH: return SIZE_H;
      LS_LW, LS_SW:         return SIZE_W;
      default:              return SIZE_B;
    endcase
  endfunction

  function automatic logic ls_misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      LS_LH, LS_LHU, LS_SH: return a[0];
      LS_LW, LS_SW:         return |a;
      default:              return 1'b0;
    endcase
  endfunction

  // Narrow stores replicate the datum across all lanes so the SRAM picks
  // the right byte/half from the address alone.
  function automatic logic [31:0] ls_wdata(input logic [3:0] op, input logic [31:0] d);
    case (op)
      LS_SB:   return {4{d[7:0]}};
      LS_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: picks the addressed byte/half from the returned word
// and sign- or zero-extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  ls_op,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (ls_op)
      LS_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LS_LBU:  result = {24'd0, byte_sel};
      LS_LH:   result = {{16{half_sel[15]}}, half_sel};
      LS_LHU:  result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues SRAM-like data requests, stalls upstream while a
// transaction is outstanding, and forms the MEM/WB result.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [3:0]  in_ls_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_alu_data,
  input  logic        in_wb_en,
  input  logic [4:0]  in_wb_addr,
  input  logic [31:0] in_excep,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        data_stall,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_excep,
  output logic [31:0] wb_badvaddr
);

  logic [2:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  mem_req_t    req_q, req_d, req_in, req_out;

  logic is_ld, is_st, is_mem, mis, go;
  logic req_raw, stall_raw;
  logic [31:0] load_res;

  assign is_ld  = ls_is_load(in_ls_op);
  assign is_st  = ls_is_store(in_ls_op);
  assign is_mem = is_ld | is_st;
  assign mis    = is_mem & ls_misaligned(in_ls_op, in_addr[1:0]);
  assign go     = in_valid & is_mem & ~mis & ~flush;

  always_comb begin
    req_in.wr    = is_st;
    req_in.size  = ls_size(in_ls_op);
    req_in.addr  = in_addr;
    req_in.wdata = ls_wdata(in_ls_op, in_wdata);
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    req_d     = req_q;
    req_out   = req_in;
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          req_raw   = 1'b1;
          stall_raw = 1'b1;
          req_d     = req_in;
          if (data_addr_ok && data_data_ok) begin
            rdata_d = data_rdata;
            state_d = S_DONE;
          end else if (data_addr_ok) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Request stays asserted with latched fields until the SRAM takes it.
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        req_out   = req_q;
        if (data_addr_ok && data_data_ok) begin
          rdata_d = data_rdata;
          state_d = flush ? S_IDLE : S_DONE;
        end else if (data_addr_ok) begin
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_raw = 1'b1;
        req_out   = req_q;
        if (data_data_ok) begin
          rdata_d = data_rdata;
          state_d = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        req_out = req_q;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        // Cancelled access still owes a data beat; swallow it before reissuing.
        req_out   = req_q;
        stall_raw = go;
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= 32'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
    end
  end

  mem_load_align u_align (
    .addr_lo (in_addr[1:0]),
    .ls_op   (in_ls_op),
    .rdata   (rdata_q),
    .result  (load_res)
  );

  logic live;
  assign live = in_valid & ~flush & ~stall_raw;

  always_comb begin
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = 32'd0;
    data_wdata  = 32'd0;
    data_stall  = 1'b0;
    wb_valid    = 1'b0;
    wb_en       = 1'b0;
    wb_addr     = 5'd0;
    wb_data     = 32'd0;
    wb_pc       = 32'd0;
    wb_excep    = 32'd0;
    wb_badvaddr = 32'd0;
    if (!rst) begin
      data_req    = req_raw;
      data_wr     = req_out.wr;
      data_size   = req_out.size;
      data_addr   = req_out.addr;
      data_wdata  = req_out.wdata;
      data_stall  = stall_raw;
      wb_valid    = live;
      wb_en       = live & in_wb_en & ~is_st & ~mis;
      wb_addr     = in_wb_addr;
      wb_data     = (is_ld & ~mis) ? load_res : in_alu_data;
      wb_pc       = in_pc;
      wb_excep    = in_excep;
      wb_excep[EXC_ADEL] = in_excep[EXC_ADEL] | (mis & is_ld);
      wb_excep[EXC_ADES] = in_excep[EXC_ADES] | (mis & is_st);
      wb_badvaddr = mis ? in_addr : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load/store paths, alignment faults, flush
// and drain behaviour, and asynchronous reset mid-transaction.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_wb_en;
  logic [31:0] in_pc, in_addr, in_wdata, in_alu_data, in_excep;
  logic [3:0]  in_ls_op;
  logic [4:0]  in_wb_addr;
  logic        data_req, data_wr, data_addr_ok, data_data_ok, data_stall;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        wb_valid, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, wb_pc, wb_excep, wb_badvaddr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_ls_op(in_ls_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_alu_data(in_alu_data), .in_wb_en(in_wb_en), .in_wb_addr(in_wb_addr),
    .in_excep(in_excep), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .data_stall(data_stall), .wb_valid(wb_valid),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .wb_excep(wb_excep), .wb_badvaddr(wb_badvaddr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_valid = 1'b0; in_ls_op = LS_NONE; in_addr = 32'd0; in_wdata = 32'd0;
    flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
    in_valid = 1'b1; in_ls_op = op; in_addr = a; in_wdata = wd;
  endtask

  // Load accepted and answered in the issue cycle, result checked in DONE.
  task automatic fast_load(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] rd, input logic [1:0] sz, input logic [31:0] exp);
    set_op(op, a, 32'd0);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rd;
    #1;
    chk({tag, "_req"}, 32'(data_req), 32'd1);
    chk({tag, "_size"}, 32'(data_size), 32'(sz));
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    #1;
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_stall"}, 32'(data_stall), 32'd0);
    cyc();
    clr();
  endtask

  initial begin
    rst = 1'b1;
    clr();
    in_pc = 32'h0000_0400; in_alu_data = 32'h0000_0077; in_wb_en = 1'b1;
    in_wb_addr = 5'd5; in_excep = 32'd0;
    set_op(LS_LW, 32'h1000, 32'd0);
    data_addr_ok = 1'b1;
    #1;
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(data_stall), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wbpc", wb_pc, 32'd0);
    clr();
    cyc(); cyc();
    rst = 1'b0;

    // LW: addr_ok cycle 0, data_ok cycle 2, DONE cycle 3
    set_op(LS_LW, 32'h1000, 32'd0);
    data_addr_ok = 1'b1;
    #1;
    chk("lw_c0_req", 32'(data_req), 32'd1);
    chk("lw_c0_stall", 32'(data_stall), 32'd1);
    chk("lw_c0_size", 32'(data_size), 32'(SIZE_W));
    chk("lw_c0_addr", data_addr, 32'h1000);
    chk("lw_c0_wr", 32'(data_wr), 32'd0);
    chk("lw_c0_wbv", 32'(wb_valid), 32'd0);
    cyc();
    data_addr_ok = 1'b0;
    #1;
    chk("lw_c1_req", 32'(data_req), 32'd0);
    chk("lw_c1_stall", 32'(data_stall), 32'd1);
    cyc();
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_c2_stall", 32'(data_stall), 32'd1);
    cyc();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    #1;
    chk("lw_c3_stall", 32'(data_stall), 32'd0);
    chk("lw_c3_wbv", 32'(wb_valid), 32'd1);
    chk("lw_c3_data", wb_data, 32'hDEAD_BEEF);
    chk("lw_c3_wben", 32'(wb_en), 32'd1);
    chk("lw_c3_wbaddr", 32'(wb_addr), 32'd5);
    cyc();
    clr();

    fast_load("lb", LS_LB, 32'h1003, 32'h80FF_FFFF, SIZE_B, 32'hFFFF_FF80);
    fast_load("lbu", LS_LBU, 32'h1003, 32'h80FF_FFFF, SIZE_B, 32'h0000_0080);
    fast_load("lh", LS_LH, 32'h1002, 32'h8001_1234, SIZE_H, 32'hFFFF_8001);
    fast_load("lhu", LS_LHU, 32'h1000, 32'h8001_F234, SIZE_H, 32'h0000_F234);

    // SH with both handshakes in one cycle
    set_op(LS_SH, 32'h2002, 32'h1234_ABCD);
    data_addr_ok = 1'b1; data_data_ok = 1'b1;
    #1;
    chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
    chk("sh_size", 32'(data_size), 32'(SIZE_H));
    chk("sh_wr", 32'(data_wr), 32'd1);
    chk("sh_addr", data_addr, 32'h2002);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    chk("sh_wbv", 32'(wb_valid), 32'd1);
    chk("sh_wben", 32'(wb_en), 32'd0);
    cyc();
    clr();

    // SB held in REQ, request fields stable
    set_op(LS_SB, 32'h3001, 32'h0000_00A5);
    #1;
    chk("sb_c0_wdata", data_wdata, 32'hA5A5_A5A5);
    cyc();
    #1;
    chk("sb_req_req", 32'(data_req), 32'd1);
    chk("sb_req_stall", 32'(data_stall), 32'd1);
    chk("sb_req_addr", data_addr, 32'h3001);
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    #1;
    chk("sb_wait_req", 32'(data_req), 32'd0);
    cyc();
    data_data_ok = 1'b0;
    #1;
    chk("sb_done_stall", 32'(data_stall), 32'd0);
    cyc();
    clr();

    // Misaligned accesses
    set_op(LS_LW, 32'h1002, 32'd0);
    #1;
    chk("adel_req", 32'(data_req), 32'd0);
    chk("adel_stall", 32'(data_stall), 32'd0);
    chk("adel_bit", 32'(wb_excep[EXC_ADEL]), 32'd1);
    chk("adel_bad", wb_badvaddr, 32'h1002);
    chk("adel_wben", 32'(wb_en), 32'd0);
    set_op(LS_SH, 32'h2001, 32'd0);
    #1;
    chk("ades_req", 32'(data_req), 32'd0);
    chk("ades_bit", 32'(wb_excep[EXC_ADES]), 32'd1);
    chk("ades_adel", 32'(wb_excep[EXC_ADEL]), 32'd0);
    cyc();
    clr();

    // Non-memory passthrough and valid gating
    set_op(LS_NONE, 32'd0, 32'd0);
    in_alu_data = 32'h0000_0055;
    #1;
    chk("alu_data", wb_data, 32'h0000_0055);
    chk("alu_wben", 32'(wb_en), 32'd1);
    chk("alu_stall", 32'(data_stall), 32'd0);
    flush = 1'b1;
    #1;
    chk("alu_flush_wbv", 32'(wb_valid), 32'd0);
    chk("alu_flush_wben", 32'(wb_en), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("alu_inv_wbv", 32'(wb_valid), 32'd0);
    cyc();
    clr();

    // Flush in WAIT, SW waits out the drain
    set_op(LS_LW, 32'h1000, 32'd0);
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    chk("fw_wbv", 32'(wb_valid), 32'd0);
    cyc();
    flush = 1'b0;
    set_op(LS_SW, 32'h4000, 32'hCAFE_F00D);
    #1;
    chk("drain_stall", 32'(data_stall), 32'd1);
    chk("drain_req", 32'(data_req), 32'd0);
    cyc();
    data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
    #1;
    chk("drain_ok_stall", 32'(data_stall), 32'd1);
    chk("drain_ok_req", 32'(data_req), 32'd0);
    cyc();
    data_data_ok = 1'b0; data_rdata = 32'd0; data_addr_ok = 1'b1;
    #1;
    chk("sw_req", 32'(data_req), 32'd1);
    chk("sw_wr", 32'(data_wr), 32'd1);
    chk("sw_addr", data_addr, 32'h4000);
    chk("sw_wdata", data_wdata, 32'hCAFE_F00D);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    cyc();
    data_data_ok = 1'b0;
    #1;
    chk("sw_done_wbv", 32'(wb_valid), 32'd1);
    chk("sw_done_wben", 32'(wb_en), 32'd0);
    cyc();
    clr();

    // Flush in REQ before addr_ok
    set_op(LS_LW, 32'h1000, 32'd0);
    cyc();
    flush = 1'b1;
    #1;
    chk("fr_req", 32'(data_req), 32'd1);
    cyc();
    clr();
    #1;
    chk("fr_idle_req", 32'(data_req), 32'd0);
    chk("fr_idle_stall", 32'(data_stall), 32'd0);
    cyc();
    fast_load("fr_lw", LS_LW, 32'h1004, 32'h0BAD_F00D, SIZE_W, 32'h0BAD_F00D);

    // Reset asserted while waiting for data
    set_op(LS_LW, 32'h1000, 32'd0);
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0;
    #1;
    chk("rw_stall", 32'(data_stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rw_req", 32'(data_req), 32'd0);
    chk("rw_stall0", 32'(data_stall), 32'd0);
    chk("rw_wbv", 32'(wb_valid), 32'd0);
    chk("rw_wbdata", wb_data, 32'd0);
    chk("rw_wbpc", wb_pc, 32'd0);
    chk("rw_daddr", data_addr, 32'd0);
    cyc();
    rst = 1'b0;
    clr();
    data_data_ok = 1'b1;
    #1;
    chk("rw_post_stall", 32'(data_stall), 32'd0);
    cyc();
    data_data_ok = 1'b0;
    set_op(LS_LW, 32'h1008, 32'd0);
    data_addr_ok = 1'b1;
    #1;
    chk("rw_idle_req", 32'(data_req), 32'd1);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    cyc();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    #1;
    chk("rw_lw_data", wb_data, 32'h1234_5678);
    cyc();
    clr();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have single clock and reset, "Already decided": one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  pipeline clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 flush  in  1  exception flush; cancels the in-stage instruction.
REQ-005 in_valid  in  1  EX/MEM register holds a live instruction.
REQ-006 in_pc  in  32  instruction PC.
REQ-007 in_ls_op  in  4  LS_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW (package codes).
REQ-008 in_addr  in  32  effective address (ALU result).
REQ-009 in_wdata  in  32  store data (rt).
REQ-010 in_alu_data, in_wb_en/in_wb_addr, in_excep  in  32/1/5/32  passthrough data, GPR write, exception vector.
REQ-011 data_req, data_wr, data_size[1:0], data_addr[31:0], data_wdata[31:0]  out  SRAM-like request; size 0=byte, 1=half, 2=word.
REQ-012 data_addr_ok, data_data_ok  in  1  address accepted / data returned; data_rdata  in  32.
REQ-013 data_stall  out  1  freezes EX/MEM and upstream (drives stall[3]).
REQ-014 wb_valid, wb_en, wb_addr[4:0], wb_data[31:0], wb_pc[31:0], wb_excep[31:0], wb_badvaddr[31:0]  out  result toward MEM/WB.

Function
REQ-015 SHALL implement FSM IDLE, REQ, WAIT, DONE, DRAIN.
REQ-016 IDLE, in_valid, memory op, aligned, no flush: data_req=1 and data_stall=1 combinationally same cycle; addr_ok -> WAIT, else -> REQ.
REQ-017 REQ: hold data_req and all request fields stable; data_stall=1; addr_ok -> WAIT.
REQ-018 WAIT: data_req=0, data_stall=1; data_ok -> capture data_rdata into rdata buffer, -> DONE.
REQ-019 DONE: data_stall=0, no request, wb outputs present buffered result; next cycle -> IDLE unconditionally.
REQ-020 addr_ok and data_ok in the same IDLE/REQ cycle SHALL go directly to DONE with data captured.
REQ-021 Alignment: LH/LHU/SH need addr[0]=0, LW/SW need addr[1:0]=0; violation SHALL issue no request, no stall, set EXC_ADEL (load) or EXC_ADES (store) in wb_excep, wb_badvaddr=in_addr, wb_en=0.
REQ-022 Stores: data_wr=1; SB wdata={4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW unchanged; data_addr=in_addr.
REQ-023 Loads: select byte/half by addr[1:0]/addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-024 Non-memory ops: zero-latency passthrough, wb_data=in_alu_data, no stall.
REQ-025 flush in REQ before addr_ok: drop data_req next cycle, -> IDLE; flush coincident with addr_ok, or in WAIT: -> DRAIN.
REQ-026 DRAIN: discard returning data_ok, data_stall=1 only if a new memory op is valid; data_ok -> IDLE.
REQ-027 flush or in_valid=0 SHALL force wb_valid=0, wb_en=0 that cycle.
REQ-028 Store results SHALL have wb_en=0; load results wb_en=in_wb_en.

Reset
REQ-029 rst SHALL force IDLE, rdata buffer 0, data_req=0, data_stall=0, all wb_* outputs 0, immediately.
REQ-030 Reset mid-transaction SHALL abandon it; no drain after reset.

Structure
REQ-031 ls_op codes, FSM state encoding, EXC_ADEL/EXC_ADES bit indices, size codes SHALL live in the shared defines package.
REQ-032 Load extraction/extension SHALL be sub-module mem_load_align (addr[1:0], ls_op, rdata -> 32-bit result).

Verification
REQ-033 LW 0x1000, addr_ok cycle 0, data_ok cycle 2 rdata 0xDEADBEEF -> stall cycles 0-2, DONE cycle 3 wb_data 0xDEADBEEF.
REQ-034 LB addr 0x1003, rdata 0x80FFFFFF -> 0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH addr 0x2002 wdata 0x1234ABCD -> data_wdata 0xABCDABCD, size 1, data_wr=1, wb_en=0.
REQ-036 LW addr 0x1002 -> no data_req, no stall, EXC_ADEL set, badvaddr 0x1002.
REQ-037 flush in WAIT, then SW valid -> DRAIN stalls, data_ok dropped, SW request issued cycle after data_ok.
REQ-038 rst asserted in WAIT -> all outputs 0 same cycle, IDLE after release.
